// File: rtl/mult_div_unit_if.sv
// Bundle of operation request, HI/LO write and result signals for mult_div_unit.
// The controller is the master; the unit itself is the slave.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    // start is a request qualified by busy: it is taken at a rising edge only
    // when busy is low (IDLE or DONE); while busy is high it is dropped,
    // with no stall or queueing. done marks the single cycle after HI/LO load.
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             writeHi;
    logic             writeLo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, a, b, writeHi, writeLo, wdata,
        input  busy, done, hi_out, lo_out, dbg_state
    );

    modport slave (
        input  start, op, a, b, writeHi, writeLo, wdata,
        output busy, done, hi_out, lo_out, dbg_state
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one bit per cycle, with a final sign-fix cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mult_div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand capture: op[0]==0 selects the signed variants.
    logic                 in_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    // Per-iteration datapath.
    logic [WIDTH:0]       mul_upper;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ge;
    // Sign-fix results.
    logic                 fix_signed, fix_neg;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    always_comb begin
        in_signed = ~bus.op[0];
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        mag_a     = a_neg ? -bus.a : bus.a;
        mag_b     = b_neg ? -bus.b : bus.b;

        mul_upper = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

        div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_ge    = rem_q[WIDTH] | (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};

        fix_signed = ~op_q[0];
        fix_neg    = fix_signed & (sign_a_q ^ sign_b_q);
        prod_fix   = fix_neg ? -acc_q : acc_q;
        quot_fix   = fix_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix    = (fix_signed & sign_a_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    cnt_d    = CW'(WIDTH - 1);
                    op_d     = bus.op;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    rem_d    = '0;
                    // Multiply keeps the multiplier in the low half and adds the
                    // multiplicand; divide shifts the dividend out of the low half.
                    if (bus.op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (bus.writeHi) hi_d = bus.wdata;
                    if (bus.writeLo) lo_d = bus.wdata;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    rem_d = div_ge ? div_diff : div_shift;
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_upper, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_FIX: begin
                state_d = S_DONE;
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    // A zero divisor leaves the dividend in the remainder, which the
                    // sign fix restores to raw a; only the quotient needs forcing.
                    lo_d = (opnd_q == '0) ? {WIDTH{1'b1}} : quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == S_RUN) || (state_q == S_FIX);
        bus.done      = (state_q == S_DONE);
        bus.hi_out    = hi_q;
        bus.lo_out    = lo_q;
        bus.dbg_state = state_q;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops against a
// behavioural model, and hand-written reset/back-to-back/ignore sequences.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference result {hi, lo} computed with wide native arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0]     res;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: begin p = ua * ub; res = p; end
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    p = ua / ub;
                    res = {32'(ua % ub), p[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        exp_q.push_back(exp);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_result(input string name, input int exp_lat);
        int          n;
        bit          seen;
        logic [63:0] e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (bus.done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, "_latency"}, 64'(n), 64'(exp_lat));
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL %s_scoreboard: done with empty expected queue", name);
            end else begin
                e = exp_q.pop_front();
                check(name, {bus.hi_out, bus.lo_out}, e);
            end
            tick();
            check({name, "_single_done"}, 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, hold_hi;
        int          ndone, first_c, gap, extra;
        bit          busy_bad;

        vecs[0]  = '{"mult_m2x3",     2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{"multu_m2x3",    2'b01, 32'hFFFF_FFFE, 32'd3,         32'd2,         32'hFFFF_FFFA};
        vecs[2]  = '{"div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_100_7",    2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4]  = '{"divu_5_0",      2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[5]  = '{"div_overflow",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[6]  = '{"div_7_m2",      2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{"div_m7_m2",     2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
        vecs[8]  = '{"mult_min_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[9]  = '{"multu_max_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
        vecs[10] = '{"div_m7_0",      2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[11] = '{"mult_7_m1",     2'b00, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.writeHi = 1'b0;
        bus.writeLo = 1'b0;
        bus.wdata   = '0;
        repeat (3) tick();
        check("reset_busy",  64'(bus.busy), 64'd0);
        check("reset_done",  64'(bus.done), 64'd0);
        check("reset_hilo",  {bus.hi_out, bus.lo_out}, 64'd0);
        check("reset_state", 64'(bus.dbg_state), 64'd0);
        rst = 1'b0;
        tick();

        // Both write enables together load both registers.
        bus.writeHi = 1'b1;
        bus.writeLo = 1'b1;
        bus.wdata   = 32'hA5A5_5A5A;
        tick();
        bus.writeHi = 1'b0;
        bus.writeLo = 1'b0;
        check("write_both", {bus.hi_out, bus.lo_out}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});

        // Reset ten cycles into a mult aborts it and clears HI/LO.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd1234;
        bus.b     = 32'd5678;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("mid_run_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        issue(2'b01, 32'd3, 32'd5, {32'd0, 32'd15});
        wait_result("multu_3x5_after_abort", 33);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
            wait_result(vecs[i].name, 33);
        end

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 4 == 1) ra = -ra;
            issue(rop, ra, rb, model(rop, ra, rb));
            wait_result("random_op", 33);
        end

        // Write attempts in the start cycle and start/writeHi while busy are ignored.
        bus.writeHi = 1'b1;
        bus.writeLo = 1'b1;
        bus.wdata   = 32'h1111_2222;
        tick();
        bus.writeLo = 1'b0;
        bus.wdata   = 32'h3333_4444;
        issue(2'b00, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        bus.writeHi = 1'b0;
        check("start_beats_write", 64'(bus.hi_out), 64'h1111_2222);
        hold_hi = bus.hi_out;
        repeat (5) tick();
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.a       = 32'd100;
        bus.b       = 32'd7;
        bus.writeHi = 1'b1;
        bus.wdata   = 32'hDEAD_BEEF;
        tick();
        bus.start   = 1'b0;
        bus.writeHi = 1'b0;
        check("hi_hold_in_run", 64'(bus.hi_out), 64'(hold_hi));
        wait_result("mult_with_noise", 27);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.done || bus.busy) extra++;
        end
        check("no_extra_op", 64'(extra), 64'd0);
        bus.writeLo = 1'b1;
        bus.wdata   = 32'h1234;
        tick();
        bus.writeLo = 1'b0;
        check("mtlo_lo", 64'(bus.lo_out), 64'h1234);
        check("mtlo_hi_kept", 64'(bus.hi_out), 64'hFFFF_FFFF);

        // start held high: the second op is accepted in the DONE cycle.
        exp_q.push_back(64'd4);
        exp_q.push_back(64'd9);
        bus.op    = 2'b01;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        bus.start = 1'b1;
        tick();
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        ndone     = 0;
        first_c   = 0;
        gap       = 0;
        busy_bad  = 1'b0;
        for (int c = 1; c <= 120 && ndone < 2; c++) begin
            tick();
            if (bus.busy == bus.done) busy_bad = 1'b1;
            if (bus.done) begin
                ndone++;
                if (exp_q.size() != 0) check("held_start_result", {bus.hi_out, bus.lo_out}, exp_q.pop_front());
                if (ndone == 1) first_c = c;
                else begin
                    gap = c - first_c;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("held_start_dones", 64'(ndone), 64'd2);
        check("held_start_gap", 64'(gap), 64'd34);
        check("held_start_busy_low_only_in_done", 64'(busy_bad), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
